// File: rtl/sub_bla_pipe16_pkg.sv
// Shared constants and per-stage record for the pipelined borrow-lookahead subtractor.
package sub_bla_pipe16_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int SUB_STAGES = 4;
  localparam int DATA_W     = NIBBLE_W * SUB_STAGES;

  // One pipeline entry: partial diff fills from the low nibble up; a/b carry the unused upper nibbles.
  typedef struct packed {
    logic              valid;
    logic              borrow;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } stage_t;

endpackage

// File: rtl/sub_bla_pipe16_bla_4bit_slice.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bi, bo = borrow out of the nibble.
module bla_4bit_slice
  import sub_bla_pipe16_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bi,
  output logic [NIBBLE_W-1:0] d,
  output logic                bo
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Each internal borrow is a flat sum of products, so no ripple inside the nibble.
  assign c[0] = bi;
  assign c[1] = g[0] | (p[0] & bi);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
  assign bo   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d = a ^ b ^ c;

endmodule

// File: rtl/sub_bla_pipe16.sv
// 16-bit subtractor, one borrow-lookahead nibble per stage, valid/ready on both sides.
module sub_bla_pipe16 #(
  parameter int STAGES = 4,
  parameter int W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         b_out,
  output logic         zero,
  output logic         ovf
);
  import sub_bla_pipe16_pkg::*;

  localparam int LAST = SUB_STAGES - 1;

  if (STAGES != SUB_STAGES || W != NIBBLE_W * STAGES) begin : g_param_check
    $error("sub_bla_pipe16 supports only STAGES=4, W=16");
  end

  logic                adv;
  stage_t              st  [0:LAST-1];
  stage_t              nxt [0:LAST];
  logic [NIBBLE_W-1:0] sa  [0:LAST];
  logic [NIBBLE_W-1:0] sb  [0:LAST];
  logic [NIBBLE_W-1:0] sd  [0:LAST];
  logic                sbi [0:LAST];
  logic                sbo [0:LAST];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    sa[0]  = a[NIBBLE_W-1:0];
    sb[0]  = b[NIBBLE_W-1:0];
    sbi[0] = b_in;
    for (int k = 1; k <= LAST; k++) begin
      sa[k]  = st[k-1].a[k*NIBBLE_W +: NIBBLE_W];
      sb[k]  = st[k-1].b[k*NIBBLE_W +: NIBBLE_W];
      sbi[k] = st[k-1].borrow;
    end
  end

  for (genvar k = 0; k <= LAST; k++) begin : g_slice
    bla_4bit_slice u_slice (
      .a  (sa[k]),
      .b  (sb[k]),
      .bi (sbi[k]),
      .d  (sd[k]),
      .bo (sbo[k])
    );
  end

  always_comb begin
    nxt[0].valid  = in_valid;
    nxt[0].borrow = sbo[0];
    nxt[0].diff   = {{(DATA_W-NIBBLE_W){1'b0}}, sd[0]};
    nxt[0].a      = a;
    nxt[0].b      = b;
    for (int k = 1; k <= LAST; k++) begin
      nxt[k]                                 = st[k-1];
      nxt[k].borrow                          = sbo[k];
      nxt[k].diff[k*NIBBLE_W +: NIBBLE_W]    = sd[k];
    end
  end

  // Output registers only load on a real result so bubbles leave the last answer in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAST; k++) st[k] <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < LAST; k++) st[k] <= nxt[k];
      out_valid <= nxt[LAST].valid;
      if (nxt[LAST].valid) begin
        diff  <= nxt[LAST].diff;
        b_out <= nxt[LAST].borrow;
        zero  <= ~|nxt[LAST].diff;
        ovf   <= (nxt[LAST].a[DATA_W-1] ^ nxt[LAST].b[DATA_W-1])
               & (nxt[LAST].diff[DATA_W-1] ^ nxt[LAST].a[DATA_W-1]);
      end
    end
  end

endmodule

// File: doc/sub_bla_pipe16.md
Name: sub_bla_pipe16

Overview:
16-bit pipelined subtractor computing diff = a - b - b_in, plus borrow-out and status flags.
- Datapath is four 4-bit borrow-lookahead slices, one slice per pipeline stage. The borrow ripples between stages through registers.
- Sits beside the 16-bit lookahead adder in the arithmetic unit and serves as its subtract counterpart.
- Uses a valid/ready handshake on both sides so that ALU sequencers can stream operand pairs.

Parameters:
- STAGES, 4, pipeline depth; fixed at 4, one nibble per stage; other values unsupported.
- W, 16, operand width; must equal 4*STAGES.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block accepts operands this cycle.
- a  in  16  minuend (unsigned or two's complement).
- b  in  16  subtrahend.
- b_in  in  1  borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- diff  out  16  a - b - b_in, modulo 2^16.
- b_out  out  1  unsigned borrow-out: 1 when a < b + b_in.
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, and is sampled only on a rising clk edge.
- Reset values: all stage valid bits = 0, out_valid = 0, diff = 0x0000, b_out = 0, zero = 0, ovf = 0. in_ready = 1 in the cycle after reset.
- Advance enable: adv = ~out_valid | out_ready. The whole pipe shifts one stage when adv = 1 and freezes when adv = 0. in_ready = adv, combinationally.
- Accept rule: a transfer occurs when in_valid & in_ready. If in_valid = 0 while adv = 1, a bubble (valid = 0) enters stage 0. Bubbles are not collapsed.
- Latency: exactly 4 cycles from accept to out_valid when there is no stall. Throughput is 1 result/cycle.
- Stage k (k = 0..3):
  - Computes nibble k from a[4k+3:4k], b[4k+3:4k] and the borrow registered by stage k-1. Stage 0 uses b_in.
  - Carries the unused upper operand nibbles forward as skew registers.
  - Accumulates lower diff nibbles.
- Slice equations, per bit:
  - g = ~a & b; p = ~(a ^ b); d = a ^ b ^ bi.
  - Lookahead: bo = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0·bi.
- Final stage registers the flags:
  - b_out = slice-3 bo.
  - zero = ~|diff.
  - ovf = (a15 ^ b15) & (diff15 ^ a15), where a15 and b15 are skew-carried.
- Output hold: diff and the flags hold stable while out_valid & ~out_ready. They change only when adv = 1.
- Operand ranges: 0x0000 - 0xFFFF with b_in = 1 is legal. It gives diff = 0x0000 and b_out = 1.
- Reset mid-operation: all in-flight entries are dropped and out_valid = 0 on the next cycle. No partial result appears.
- Simultaneous accept and output: when out_ready = 1 with a full pipe, one result leaves and one operand pair enters in the same cycle.
- Operand capture: a, b and b_in are sampled only on accept. Changes while in_ready = 0 are ignored.

Decomposition:
- Shared arithmetic package holds:
  - constants NIBBLE_W = 4 and SUB_STAGES = 4;
  - a typedef for the per-stage record: valid, borrow, partial diff, skewed a/b remainder.
- One natural combinational sub-module: bla_4bit_slice, with inputs a[3:0], b[3:0], bi and outputs d[3:0], bo. It is instantiated once per stage.
- Pipeline registers and handshake stay in sub_bla_pipe16.

Test Plan:
1. a=0x0005, b=0x0003, b_in=0, out_ready=1 -> 4 cycles after accept: diff=0x0002, b_out=0, zero=0, ovf=0.
2. a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, ovf=0; this exercises the borrow ripple through all 4 stages.
3. a=0x8000, b=0x0001 -> diff=0x7FFF, b_out=0, ovf=1; then a=0x7FFF, b=0xFFFF -> diff=0x8000, b_out=1, ovf=1.
4. a=0x1234, b=0x1233, b_in=1 -> diff=0x0000, zero=1, b_out=0.
5. Stream 6 back-to-back pairs with out_ready held 0 for cycles 5-7:
   - in_ready=0 during the stall;
   - no result is lost or duplicated;
   - order is preserved;
   - diff stays stable while held.
6. Assert rst with 3 operations in flight -> next cycle: out_valid=0, diff=0x0000; the next accepted pair returns the correct result after 4 cycles.
